// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit buffer: register map, STATUS layout, FSM states.
// No logic of its own; latency and backpressure are defined by the blocks that import it.
// The reset baud divisor assumes a 50 MHz clock and 115200 baud.
package uart_tx_pkg;

    localparam int DEFAULT_DIV = 434;

    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_BAUD_DIV = 2'd2;
    localparam logic [1:0] REG_RSVD     = 2'd3;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_MSB = 7;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef struct packed {
        logic [3:0] count;
        logic       ovf;
        logic       busy;
        logic       empty;
        logic       full;
    } status_t;

    // A zero divisor would stall the bit timer forever, so it is promoted to 1.
    function automatic logic [15:0] sanitize_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with combinational head (first-word fall-through) and occupancy count.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module fifo_sync_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    // Storage carries no reset; reset only needs to empty the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serializer with programmable divisor.
// Latency: byte written at edge N is popped at N+1; start bit drives tx from edge N+1.
// Backpressure: none on the bus; writes to a full FIFO are dropped and flagged in sticky OVF.
module uart_tx_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = uart_tx_pkg::DEFAULT_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  tx
);

    import uart_tx_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       reg_sel;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [7:0]       head;
    logic [7:0]       cnt_ext;

    logic             ovf;
    logic             ovf_set;
    logic             status_rd;
    logic [15:0]      baud_div;
    status_t          status;

    tx_state_t        state;
    tx_state_t        next_state;
    logic [15:0]      div_lat;
    logic [15:0]      bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       sh_nxt;
    logic             period_end;
    logic             busy;
    logic             tx_d;
    logic             tx_q;
    logic             unused_bits;

    assign reg_sel   = address[3:2];
    assign push      = we && (reg_sel == REG_TXDATA);
    assign status_rd = re && (reg_sel == REG_STATUS);
    assign ovf_set   = push && full && !pop;
    assign cnt_ext   = 8'(count);
    assign status    = {cnt_ext[3:0], ovf, busy, empty, full};
    assign tx        = tx_q;

    assign unused_bits = ^{address[DATA_WIDTH-1:4], address[1:0],
                           wd[DATA_WIDTH-1:16], cnt_ext[7:4]};

    fifo_sync_param #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (wd[7:0]),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // A set in the same cycle as a clearing STATUS read takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            baud_div <= 16'(DEFAULT_DIV);
        end else begin
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (status_rd) begin
                ovf <= 1'b0;
            end
            if (we && (reg_sel == REG_BAUD_DIV)) begin
                baud_div <= sanitize_div(wd[15:0]);
            end
        end
    end

    always_comb begin
        rd = '0;
        if (re) begin
            case (reg_sel)
                REG_STATUS:   rd = DATA_WIDTH'(status);
                REG_BAUD_DIV: rd = DATA_WIDTH'(baud_div);
                default:      rd = '0;
            endcase
        end
    end

    assign period_end = (bit_cnt == div_lat - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            TX_IDLE:  if (!empty)                         next_state = TX_START;
            TX_START: if (period_end)                     next_state = TX_DATA;
            TX_DATA:  if (period_end && bit_idx == 3'd7)  next_state = TX_STOP;
            TX_STOP:  if (period_end)                     next_state = TX_IDLE;
            default:                                      next_state = TX_IDLE;
        endcase
    end

    // tx is looked up from the next state so the registered line changes on the state edge.
    always_comb begin
        pop    = (state == TX_IDLE) && !empty;
        busy   = (state != TX_IDLE) || pop;
        sh_nxt = shreg;
        if (pop) begin
            sh_nxt = head;
        end else if (state == TX_DATA && period_end) begin
            sh_nxt = {1'b0, shreg[7:1]};
        end
        case (next_state)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = sh_nxt[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_lat <= 16'd1;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
        end else begin
            shreg <= sh_nxt;
            tx_q  <= tx_d;
            if (pop) begin
                div_lat <= baud_div;
            end
            if (state == TX_IDLE || period_end) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 16'd1;
            end
            if (state != TX_DATA) begin
                bit_idx <= '0;
            end else if (period_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: bus-driven stimulus, serial-line monitor decoding frames
// against a queue of expected bytes, divisors and back-to-back gap expectations.
module tb_uart_tx_buffer;

    localparam logic [31:0] A_TXDATA = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_BAUD   = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wd;
    logic [31:0] address;
    logic        we;
    logic        re;
    logic [31:0] rd;
    logic        tx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] b;
        int         div;
        bit         b2b;
    } frame_t;

    frame_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_buffer #(
        .DATA_WIDTH  (32),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (434)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wd      (wd),
        .address (address),
        .we      (we),
        .re      (re),
        .rd      (rd),
        .tx      (tx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; address = a; wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        re = 1'b1; address = a;
        #1 d = rd;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] b, input int div, input bit b2b);
        frame_t f;
        f.b = b; f.div = div; f.b2b = b2b;
        exp_q.push_back(f);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            bus_read(A_STATUS, s);
            n++;
        end while (s[2:0] != 3'b010 && n < budget);
        check_eq(tag, {29'd0, s[2:0]}, 32'h2);
    endtask

    task automatic wait_tx_low(input string tag, input int budget);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, tx}, 32'h0);
    endtask

    // Serial monitor: every cycle of a frame is compared to the ideal 8N1 waveform.
    initial begin
        frame_t     f;
        int         s;
        int         werr;
        int         bp;
        int         last_end;
        logic [7:0] got;
        logic       lvl;
        bit         aborted;
        last_end = -100;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                s = cyc;
                check_eq("frame_expected", {31'd0, exp_q.size() > 0}, 32'h1);
                if (exp_q.size() == 0) begin
                    while (tx === 1'b0 && rst_n === 1'b1) @(negedge clk);
                end else begin
                    f = exp_q.pop_front();
                    if (f.b2b) check_eq("frame_gap", s - last_end - 1, 1);
                    werr = 0; got = '0; aborted = 0;
                    for (int k = 0; k < 10 * f.div; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1;
                            break;
                        end
                        bp = k / f.div;
                        if (bp == 0)      lvl = 1'b0;
                        else if (bp == 9) lvl = 1'b1;
                        else              lvl = f.b[bp-1];
                        if (tx !== lvl) werr++;
                        if (bp >= 1 && bp <= 8 && (k % f.div) == f.div / 2) got[bp-1] = tx;
                    end
                    if (!aborted) begin
                        check_eq("frame_byte", {24'd0, got}, {24'd0, f.b});
                        check_eq("frame_wave_errs", werr, 0);
                        last_end = cyc;
                    end
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          n;
        rst_n = 1'b0; we = 1'b0; re = 1'b0; wd = '0; address = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_high", {31'd0, tx}, 32'h1);
        check_eq("rst_rd_re_low", rd, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(A_STATUS, r); check_eq("rst_status", r, 32'h2);
        bus_read(A_BAUD, r);   check_eq("rst_baud", r, 32'd434);
        bus_write(A_RSVD, 32'h1234);
        bus_read(A_RSVD, r);   check_eq("rsvd_read_zero", r, 32'h0);
        bus_read(A_BAUD, r);   check_eq("rsvd_write_ignored", r, 32'd434);

        // 0x55 at divisor 4: 40-clock frame
        bus_write(A_BAUD, 32'd4);
        expect_frame(8'h55, 4, 0);
        bus_write(A_TXDATA, 32'h55);
        wait_idle("idle_0x55", 200);

        // divisor 0 reads back as 1; 0xFF frame is 10 clocks, busy 11 including pop cycle
        bus_write(A_BAUD, 32'd0);
        bus_read(A_BAUD, r); check_eq("baud_zero_as_one", r, 32'd1);
        expect_frame(8'hFF, 1, 0);
        bus_write(A_TXDATA, 32'hFF);
        n = 0;
        re = 1'b1; address = A_STATUS;
        #1;
        while (rd[2] && n < 50) begin
            n++;
            @(negedge clk);
            #1;
        end
        re = 1'b0;
        check_eq("div1_busy_cycles", n, 11);
        wait_idle("idle_div1", 50);

        // burst of 10 writes: first popped at once, 8 fill the FIFO, 10th overflows
        bus_write(A_BAUD, 32'd4);
        for (int i = 0; i < 10; i++) begin
            if (i < 9) expect_frame(8'hA0 + 8'(i), 4, i > 0);
            bus_write(A_TXDATA, 32'hA0 + i);
        end
        bus_read(A_STATUS, r); check_eq("burst_status_ovf", r, 32'h8D);
        bus_read(A_STATUS, r); check_eq("burst_ovf_cleared", r, 32'h85);
        wait_idle("idle_burst", 600);

        // divisor change mid-frame applies only to the next frame
        expect_frame(8'h3C, 4, 0);
        bus_write(A_TXDATA, 32'h3C);
        repeat (6) @(negedge clk);
        bus_write(A_BAUD, 32'd8);
        bus_read(A_BAUD, r); check_eq("baud_8_readback", r, 32'd8);
        expect_frame(8'hA5, 8, 1);
        bus_write(A_TXDATA, 32'hA5);
        wait_idle("idle_divchg", 300);

        // full FIFO, push lands in the pop cycle at the next frame start
        bus_write(A_BAUD, 32'd2);
        expect_frame(8'h10, 2, 0);
        bus_write(A_TXDATA, 32'h10);
        for (int i = 1; i <= 8; i++) begin
            expect_frame(8'h10 + 8'(i), 2, 1);
            bus_write(A_TXDATA, 32'h10 + i);
        end
        bus_read(A_STATUS, r); check_eq("full_status", r, 32'h85);
        repeat (12) @(negedge clk);
        expect_frame(8'h19, 2, 1);
        bus_write(A_TXDATA, 32'h19);
        bus_read(A_STATUS, r); check_eq("push_pop_full", r, 32'h85);
        wait_idle("idle_pushpop", 400);

        // reset during DATA bit 3 aborts the frame and flushes the FIFO
        bus_write(A_BAUD, 32'd4);
        expect_frame(8'hF0, 4, 0);
        bus_write(A_TXDATA, 32'hF0);
        bus_write(A_TXDATA, 32'h77);
        wait_tx_low("start_seen", 10);
        repeat (17) @(negedge clk);
        check_eq("bit3_low", {31'd0, tx}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_tx", {31'd0, tx}, 32'h1);
        check_eq("rst_mid_rd_re_low", rd, 32'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(A_STATUS, r); check_eq("post_rst_status", r, 32'h2);
        bus_read(A_BAUD, r);   check_eq("post_rst_baud", r, 32'd434);
        repeat (60) @(negedge clk);
        bus_read(A_STATUS, r); check_eq("post_rst_still_empty", r, 32'h2);
        check_eq("post_rst_tx_idle", {31'd0, tx}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
